simon_seq_ctrl: RTL

Game sequencer for the Simon Says core. It pulls one new pseudo-random step per round from the random-index reader by pulsing `r_en`, and stores the growing pattern in a local buffer because the reader only advances forward. Each round it plays the pattern back on the LEDs, then checks the player's button presses against it. It sits between the random-index reader, the debounced button front end and the LED/score drivers.

---
 rtl/simon_seq_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/simon_seq_ctrl.sv
// Simon Says game sequencer: grows a random pattern one step per round,
// plays it back on the LEDs and checks the player's presses against it.
module simon_seq_ctrl #(
    parameter int MAX_LEN       = 16,
    parameter int SHOW_TICKS    = 12_000_000,
    parameter int GAP_TICKS     = 4_000_000,
    parameter int TIMEOUT_TICKS = 60_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   rnd,
    input  logic [3:0]                   btn,
    output logic                         r_en,
    output logic [3:0]                   led,
    output logic [$clog2(MAX_LEN+1)-1:0] round,
    output logic                         busy,
    output logic                         win,
    output logic                         lose
);
    // state    | meaning
    // IDLE     | waiting for the first start after reset
    // APPEND   | strobe reader, store one new step
    // SHOW_ON  | LED for pattern step ptr is lit
    // SHOW_OFF | dark gap after a lit step
    // INPUT    | waiting for the press matching step ptr
    // WIN      | full pattern repeated, hold until start
    // LOSE     | wrong press or timeout, hold until start
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_APPEND   = 3'd1;
    localparam logic [2:0] ST_SHOW_ON  = 3'd2;
    localparam logic [2:0] ST_SHOW_OFF = 3'd3;
    localparam logic [2:0] ST_INPUT    = 3'd4;
    localparam logic [2:0] ST_WIN      = 3'd5;
    localparam logic [2:0] ST_LOSE     = 3'd6;

    localparam int LW    = $clog2(MAX_LEN + 1);
    localparam int PW    = $clog2(MAX_LEN);
    localparam int MAX_T = (SHOW_TICKS > GAP_TICKS)
                         ? ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS)
                         : ((GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS);
    localparam int TW    = $clog2(MAX_T + 1);

    // Timers count down from N-1; reaching zero marks the last cycle of a phase.
    localparam logic [TW-1:0] SHOW_LD    = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] GAP_LD     = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_TICKS - 1);

    logic [2:0]    state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    mem_q [MAX_LEN];
    logic          mem_we;

    logic [1:0] cur_step;
    logic [3:0] cur_led;
    logic       ptr_last;
    logic       len_full;
    logic       timer_done;

    assign cur_step   = mem_q[ptr_q[PW-1:0]];
    assign cur_led    = 4'b0001 << cur_step;
    assign ptr_last   = (ptr_q == len_q - LW'(1));
    assign len_full   = (len_q == LW'(MAX_LEN));
    assign timer_done = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    len_d   = '0;
                    state_d = ST_APPEND;
                end
            end
            ST_APPEND: begin
                mem_we  = 1'b1;
                len_d   = len_q + LW'(1);
                ptr_d   = '0;
                timer_d = SHOW_LD;
                state_d = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (timer_done) begin
                    timer_d = GAP_LD;
                    state_d = ST_SHOW_OFF;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_SHOW_OFF: begin
                if (!timer_done) begin
                    timer_d = timer_q - TW'(1);
                end else if (ptr_last) begin
                    ptr_d   = '0;
                    timer_d = TIMEOUT_LD;
                    state_d = ST_INPUT;
                end else begin
                    ptr_d   = ptr_q + LW'(1);
                    timer_d = SHOW_LD;
                    state_d = ST_SHOW_ON;
                end
            end
            ST_INPUT: begin
                // A press on the timeout cycle wins over the timeout.
                if (btn == 4'b0000) begin
                    if (timer_done) state_d = ST_LOSE;
                    else            timer_d = timer_q - TW'(1);
                end else if (btn == cur_led) begin
                    timer_d = TIMEOUT_LD;
                    if (!ptr_last)     ptr_d   = ptr_q + LW'(1);
                    else if (len_full) state_d = ST_WIN;
                    else               state_d = ST_APPEND;
                end else begin
                    state_d = ST_LOSE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
        end
    end

    // Pattern storage survives reset; len bounds what is ever read back.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[len_q[PW-1:0]] <= rnd;
    end

    assign r_en  = (state_q == ST_APPEND);
    assign busy  = (state_q == ST_APPEND) || (state_q == ST_SHOW_ON) ||
                   (state_q == ST_SHOW_OFF) || (state_q == ST_INPUT);
    assign win   = (state_q == ST_WIN);
    assign lose  = (state_q == ST_LOSE);
    assign round = len_q;

    always_comb begin
        led = 4'b0000;
        if (state_q == ST_SHOW_ON) led = cur_led;
        else if (state_q == ST_WIN) led = 4'b1111;
    end

endmodule
